// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared constants for the scoreboarded register file
//
// Purpose : debug FSM state encoding and the read-port upper bound shared by
//           regfile_sb and regfile_dbg_arb.
// Ports   : none (package).
package regfile_sb_pkg;

  // Largest supported number of read ports.
  localparam int RD_PORTS_MAX = 4;

  // Debug arbiter states.
  localparam logic [1:0] DBG_IDLE  = 2'd0;
  localparam logic [1:0] DBG_STALL = 2'd1;
  localparam logic [1:0] DBG_RESP  = 2'd2;

endpackage

// File: rtl/regfile_dbg_arb.sv
// rtl/regfile_dbg_arb.sv - debug access arbiter with starvation stall
//
// Purpose : sequences a held debug request around pipeline write-back. The
//           access commits on a cycle with no write-back; after STARVE_MAX
//           consecutive blocked cycles it asks the pipeline to stall.
// Ports   : clk, rst_n        clock, async active-low reset
//           dbg_req_i         debug request, held until dbg_gnt_o
//           w_en_i            pipeline write-back enable (blocks the commit)
//           commit_o          access commits at the coming edge
//           dbg_gnt_o         one-cycle completion pulse
//           dbg_stall_o       request to suppress write-back
module regfile_dbg_arb
  import regfile_sb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dbg_req_i,
  input  logic w_en_i,
  output logic commit_o,
  output logic dbg_gnt_o,
  output logic dbg_stall_o
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_o = 1'b0;
    case (state_q)
      DBG_IDLE: begin
        if (dbg_req_i) begin
          if (!w_en_i) begin
            commit_o = 1'b1;
            state_d  = DBG_RESP;
          end else begin
            // The counter never passes STARVE_MAX: reaching it leaves IDLE.
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_W'(STARVE_MAX)) begin
              state_d = DBG_STALL;
            end
          end
        end
      end
      DBG_STALL: begin
        if (!w_en_i) begin
          commit_o = 1'b1;
          state_d  = DBG_RESP;
        end
      end
      DBG_RESP: begin
        cnt_d   = '0;
        state_d = DBG_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = DBG_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DBG_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_gnt_o   = (state_q == DBG_RESP);
  assign dbg_stall_o = (state_q == DBG_STALL);

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with bypass, busy scoreboard and debug port
//
// Purpose : decode-stage integer register file. Register 0 reads as zero and
//           ignores writes. Read ports are combinational with optional
//           write-back forwarding; a per-register busy bit tracks issued
//           producers; a debug port commits only on write-back-free cycles.
// Ports   : clk, rst_n               clock, async active-low reset
//           r_addr_i / r_data_o      packed per-port read address / data
//           r_busy_o                 per-port outstanding-producer flag
//           w_en_i/w_addr_i/w_data_i pipeline write-back
//           iss_en_i/iss_addr_i      issue with destination (sets busy)
//           flush_i                  clears all busy bits
//           dbg_*                    handshaked debug access, dbg_stall_o
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_NUM    = 32,
  parameter int ADDR_W     = $clog2(REG_NUM),
  parameter int RD_PORTS   = 2,
  parameter int BYPASS     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RD_PORTS*ADDR_W-1:0]   r_addr_i,
  output logic [RD_PORTS*DATA_W-1:0]   r_data_o,
  output logic [RD_PORTS-1:0]          r_busy_o,
  input  logic                         w_en_i,
  input  logic [ADDR_W-1:0]            w_addr_i,
  input  logic [DATA_W-1:0]            w_data_i,
  input  logic                         iss_en_i,
  input  logic [ADDR_W-1:0]            iss_addr_i,
  input  logic                         flush_i,
  input  logic                         dbg_req_i,
  input  logic                         dbg_we_i,
  input  logic [ADDR_W-1:0]            dbg_addr_i,
  input  logic [DATA_W-1:0]            dbg_wdata_i,
  output logic                         dbg_gnt_o,
  output logic [DATA_W-1:0]            dbg_rdata_o,
  output logic                         dbg_stall_o
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(REG_NUM);

  logic [DATA_W-1:0]  mem_q [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [DATA_W-1:0]  dbg_rdata_q;
  logic [DATA_W-1:0]  dbg_stored;
  logic               dbg_commit;

  // Guards against addresses past the last register when REG_NUM is not a
  // power of two.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < ADDR_LIMIT);
  endfunction

  regfile_dbg_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_dbg_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .dbg_req_i   (dbg_req_i),
    .w_en_i      (w_en_i),
    .commit_o    (dbg_commit),
    .dbg_gnt_o   (dbg_gnt_o),
    .dbg_stall_o (dbg_stall_o)
  );

  // Storage. Entry 0 is only ever loaded by reset, so it stays zero. A debug
  // commit can only happen with w_en_i low, so the two writers never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (w_en_i && (w_addr_i == ADDR_W'(i))) begin
          mem_q[i] <= w_data_i;
        end else if (dbg_commit && dbg_we_i && (dbg_addr_i == ADDR_W'(i))) begin
          mem_q[i] <= dbg_wdata_i;
        end
      end
    end
  end

  // Scoreboard: issue beats write-back on the same register, flush beats all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (flush_i) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (iss_en_i && (iss_addr_i == ADDR_W'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (w_en_i && (w_addr_i == ADDR_W'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Debug reads see the stored value only, never the bypass path.
  assign dbg_stored = addr_ok(dbg_addr_i) ? mem_q[dbg_addr_i] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata_q <= '0;
    end else if (dbg_commit && !dbg_we_i) begin
      dbg_rdata_q <= dbg_stored;
    end
  end

  assign dbg_rdata_o = dbg_rdata_q;

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    if (k < RD_PORTS_MAX) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic              hit;
      logic [DATA_W-1:0] stored;
      logic              busy_bit;

      assign addr     = r_addr_i[k*ADDR_W +: ADDR_W];
      assign hit      = (BYPASS != 0) && w_en_i && (w_addr_i == addr)
                        && (addr != '0) && addr_ok(addr);
      assign stored   = addr_ok(addr) ? mem_q[addr] : '0;
      assign busy_bit = addr_ok(addr) ? busy_q[addr] : 1'b0;

      assign r_data_o[k*DATA_W +: DATA_W] = hit ? w_data_i : stored;
      assign r_busy_o[k]                  = busy_bit & ~hit;
    end else begin : g_unsupported
      assign r_data_o[k*DATA_W +: DATA_W] = '0;
      assign r_busy_o[k]                  = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NP*AW-1:0] r_addr;
  logic [NP*DW-1:0] r_data_a, r_data_b;
  logic [NP-1:0]  r_busy_a, r_busy_b;
  logic           w_en;
  logic [AW-1:0]  w_addr;
  logic [DW-1:0]  w_data;
  logic           iss_en;
  logic [AW-1:0]  iss_addr;
  logic           flush;
  logic           dbg_req, dbg_we;
  logic [AW-1:0]  dbg_addr;
  logic [DW-1:0]  dbg_wdata;
  logic           gnt_a, gnt_b, stall_a, stall_b;
  logic [DW-1:0]  rdata_a, rdata_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .REG_NUM(32), .ADDR_W(AW), .RD_PORTS(NP),
               .BYPASS(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .r_addr_i(r_addr), .r_data_o(r_data_a),
    .r_busy_o(r_busy_a), .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(gnt_a), .dbg_rdata_o(rdata_a),
    .dbg_stall_o(stall_a));

  regfile_sb #(.DATA_W(DW), .REG_NUM(32), .ADDR_W(AW), .RD_PORTS(NP),
               .BYPASS(0), .STARVE_MAX(4)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .r_addr_i(r_addr), .r_data_o(r_data_b),
    .r_busy_o(r_busy_b), .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(gnt_b), .dbg_rdata_o(rdata_b),
    .dbg_stall_o(stall_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    r_addr = {p1, p0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_en = 0; w_addr = 0; w_data = 0; iss_en = 0; iss_addr = 0;
    flush = 0; dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    set_raddr(5'd5, 5'd31);
    repeat (2) step();
    n_checks++;
    if ({gnt_a, stall_a, rdata_a} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL reset_dbg: got gnt=%b stall=%b rdata=%h, want 0 0 0", gnt_a, stall_a, rdata_a);
    end
    n_checks++;
    if ({r_data_a, r_busy_a} !== '0) begin
      n_fail++; $display("FAIL reset_read: got data=%h busy=%b, want 0", r_data_a, r_busy_a);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    set_raddr(5'd0, 5'd5);
    w_en = 1; w_addr = 5'd5; w_data = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (r_data_a[DW +: DW] !== exp_v) begin
      n_fail++; $display("FAIL bypass_on: got %h, want %h", r_data_a[DW +: DW], exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if (r_data_b[DW +: DW] !== exp_v) begin
      n_fail++; $display("FAIL bypass_off: got %h, want %h", r_data_b[DW +: DW], exp_v);
    end
    step();
    w_en = 0;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({r_data_a[DW +: DW], r_data_b[DW +: DW]} !== {exp_v, exp_v}) begin
      n_fail++; $display("FAIL stored_read: got %h/%h, want %h", r_data_a[DW +: DW], r_data_b[DW +: DW], exp_v);
    end
    // Register 0 ignores writes and is never busy.
    w_en = 1; w_addr = 5'd0; w_data = 32'hFFFF_FFFF; iss_en = 1; iss_addr = 5'd0;
    step();
    w_en = 0; iss_en = 0;
    #1; n_checks++;
    if ({r_data_a[DW-1:0], r_busy_a[0]} !== 33'h0) begin
      n_fail++; $display("FAIL reg0_write: got data=%h busy=%b, want 0 0", r_data_a[DW-1:0], r_busy_a[0]);
    end
  endtask

  task automatic test_scoreboard();
    set_raddr(5'd7, 5'd0);
    iss_en = 1; iss_addr = 5'd7;
    step();
    iss_en = 0;
    for (int c = 0; c < 3; c++) begin
      #1; n_checks++;
      if (r_busy_a[0] !== 1'b1) begin
        n_fail++; $display("FAIL busy_pending%0d: got %b, want 1", c, r_busy_a[0]);
      end
      step();
    end
    w_en = 1; w_addr = 5'd7; w_data = 32'h0000_0777;
    #1; n_checks++;
    if ({r_busy_a[0], r_busy_b[0]} !== 2'b01) begin
      n_fail++; $display("FAIL busy_wb_cycle: got bypass=%b nobypass=%b, want 0 1", r_busy_a[0], r_busy_b[0]);
    end
    step();
    w_en = 0;
    #1; n_checks++;
    if ({r_busy_a[0], r_busy_b[0], r_data_a[DW-1:0]} !== {2'b00, 32'h0000_0777}) begin
      n_fail++; $display("FAIL busy_cleared: got busy=%b%b data=%h, want 00 777", r_busy_a[0], r_busy_b[0], r_data_a[DW-1:0]);
    end
    // Same-cycle issue and write-back: set wins.
    iss_en = 1; iss_addr = 5'd9; w_en = 1; w_addr = 5'd9; w_data = 32'h99;
    step();
    iss_en = 1; iss_addr = 5'd3; w_en = 0;
    step();
    iss_en = 0;
    set_raddr(5'd3, 5'd9);
    #1; n_checks++;
    if (r_busy_a !== 2'b11) begin
      n_fail++; $display("FAIL set_wins: got busy=%b, want 11", r_busy_a);
    end
    flush = 1; iss_en = 1; iss_addr = 5'd3;
    step();
    flush = 0; iss_en = 0;
    #1; n_checks++;
    if ({r_busy_a, r_busy_b} !== 4'b0000) begin
      n_fail++; $display("FAIL flush: got busy=%b/%b, want 00/00", r_busy_a, r_busy_b);
    end
  endtask

  // Drives a debug access and waits (bounded) for the grant; returns the
  // number of cycles counting the request cycle as cycle 1.
  task automatic dbg_access(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, output int cyc);
    dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    cyc = 1;
    #1;
    while (!gnt_a && cyc < 20) begin
      step(); cyc++;
    end
    dbg_req = 0;
  endtask

  task automatic test_debug();
    int cyc;
    dbg_access(1'b1, 5'd0, 32'h1234, cyc);
    n_checks++;
    if ({gnt_a, cyc} !== {1'b1, 32'd2}) begin
      n_fail++; $display("FAIL dbg_wr_reg0_gnt: got gnt=%b cycles=%0d, want 1 2", gnt_a, cyc);
    end
    step();
    set_raddr(5'd0, 5'd4);
    #1; n_checks++;
    if ({gnt_a, r_data_a[DW-1:0]} !== 33'h0) begin
      n_fail++; $display("FAIL dbg_reg0_read: got gnt=%b data=%h, want 0 0", gnt_a, r_data_a[DW-1:0]);
    end
    w_en = 1; w_addr = 5'd4; w_data = 32'h55;
    step();
    w_en = 0;
    exp_q.push_back(32'h55);
    dbg_access(1'b0, 5'd4, 32'h0, cyc);
    exp_v = exp_q.pop_front(); n_checks++;
    if ({gnt_a, cyc, rdata_a} !== {1'b1, 32'd2, exp_v}) begin
      n_fail++; $display("FAIL dbg_read: got gnt=%b cycles=%0d rdata=%h, want 1 2 %h", gnt_a, cyc, rdata_a, exp_v);
    end
    step();
    // A debug write must not disturb a pending producer.
    iss_en = 1; iss_addr = 5'd6;
    step();
    iss_en = 0;
    dbg_access(1'b1, 5'd6, 32'hAA, cyc);
    step();
    set_raddr(5'd6, 5'd4);
    #1; n_checks++;
    if ({r_busy_a[0], r_data_a[DW-1:0]} !== {1'b1, 32'hAA}) begin
      n_fail++; $display("FAIL dbg_wr_busy: got busy=%b data=%h, want 1 aa", r_busy_a[0], r_data_a[DW-1:0]);
    end
  endtask

  task automatic test_starve();
    int blocked;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd4;
    w_en = 1; w_addr = 5'd10; w_data = 32'hA5A5;
    exp_q.push_back(32'h55);
    blocked = 0;
    #1;
    while (!stall_a && blocked < 12) begin
      n_checks++;
      if (gnt_a !== 1'b0) begin
        n_fail++; $display("FAIL starve_early_gnt: got gnt=%b, want 0", gnt_a);
      end
      step(); blocked++;
    end
    n_checks++;
    if ({stall_a, blocked} !== {1'b1, 32'd4}) begin
      n_fail++; $display("FAIL starve_stall: got stall=%b after %0d cycles, want 1 after 4", stall_a, blocked);
    end
    step();
    n_checks++;
    if ({stall_a, gnt_a} !== 2'b10) begin
      n_fail++; $display("FAIL stall_hold: got stall=%b gnt=%b, want 1 0", stall_a, gnt_a);
    end
    w_en = 0;
    step();
    dbg_req = 0;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({gnt_a, stall_a, rdata_a} !== {2'b10, exp_v}) begin
      n_fail++; $display("FAIL stall_commit: got gnt=%b stall=%b rdata=%h, want 1 0 %h", gnt_a, stall_a, rdata_a, exp_v);
    end
    step();
    n_checks++;
    if ({gnt_a, stall_a} !== 2'b00) begin
      n_fail++; $display("FAIL stall_done: got gnt=%b stall=%b, want 0 0", gnt_a, stall_a);
    end
  endtask

  task automatic test_reset_mid();
    int blocked;
    logic saw_gnt;
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd11; dbg_wdata = 32'h77;
    w_en = 1; w_addr = 5'd12; w_data = 32'h12;
    blocked = 0;
    #1;
    while (!stall_a && blocked < 12) begin
      step(); blocked++;
    end
    n_checks++;
    if (stall_a !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_setup: got stall=%b, want 1", stall_a);
    end
    #2;
    rst_n = 0; w_en = 0;
    #1; n_checks++;
    if ({gnt_a, stall_a, rdata_a} !== {2'b00, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_outputs: got gnt=%b stall=%b rdata=%h, want 0 0 0", gnt_a, stall_a, rdata_a);
    end
    saw_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(); saw_gnt |= gnt_a;
    end
    dbg_req = 0;
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      step(); saw_gnt |= gnt_a;
    end
    n_checks++;
    if (saw_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_gnt: got gnt pulse=%b, want 0", saw_gnt);
    end
    set_raddr(5'd11, 5'd4);
    #1; n_checks++;
    if ({r_data_a, r_busy_a} !== '0) begin
      n_fail++; $display("FAIL rst_mid_regs: got data=%h busy=%b, want 0", r_data_a, r_busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_debug();
    test_starve();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
